// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared control-bundle layout, opcode and encoding constants for
//            the in-order pipeline control unit.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

   localparam int CTRL_W = 14;

   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_I      = 7'b0010011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] c_ALU_ADD     = 3'b000;
   localparam logic [2:0] c_ALU_CMP     = 3'b001;
   localparam logic [2:0] c_ALU_FUNCT   = 3'b010;
   localparam logic [2:0] c_ALU_PASSIMM = 3'b011;
   localparam logic [2:0] c_ALU_PCADD   = 3'b100;

   localparam logic [2:0] c_IMM_I = 3'b000;
   localparam logic [2:0] c_IMM_S = 3'b001;
   localparam logic [2:0] c_IMM_B = 3'b010;
   localparam logic [2:0] c_IMM_U = 3'b011;
   localparam logic [2:0] c_IMM_J = 3'b100;

   // Bit offsets inside the flat CTRL_W-bit bundle (LSB first)
   localparam int c_BIT_PC4SEL     = 0;
   localparam int c_BIT_REGWRITE   = 1;
   localparam int c_BIT_MEMTOREG   = 2;
   localparam int c_BIT_MEMWRITE   = 3;
   localparam int c_BIT_MEMREAD    = 4;
   localparam int c_BIT_JUMP       = 5;
   localparam int c_BIT_BRANCH     = 6;
   localparam int c_BIT_IMMSEL_LSB = 7;
   localparam int c_BIT_ALUSRC     = 10;
   localparam int c_BIT_ALUOP_LSB  = 11;

   typedef struct packed {
      logic [2:0] aluop;
      logic       alusrc;
      logic [2:0] immsel;
      logic       branch;
      logic       jump;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       pc4sel;
   } ctrl_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Purely combinational opcode decoder producing the control bundle
//            and source-register usage flags.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [6:0]            opcode,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic [CTRL_W-1:0]     bundle,
   output logic                  illegal,
   output logic                  uses_rs1,
   output logic                  uses_rs2
);

   ctrl_t w_ctrl;

   always_comb begin
      w_ctrl   = '0;
      illegal  = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         c_OP_R: begin
            w_ctrl.aluop    = c_ALU_FUNCT;
            w_ctrl.regwrite = 1'b1;
            uses_rs1        = 1'b1;
            uses_rs2        = 1'b1;
         end
         c_OP_I: begin
            w_ctrl.aluop    = c_ALU_FUNCT;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.immsel   = c_IMM_I;
            w_ctrl.regwrite = 1'b1;
            uses_rs1        = 1'b1;
         end
         c_OP_LOAD: begin
            w_ctrl.aluop    = c_ALU_ADD;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.immsel   = c_IMM_I;
            w_ctrl.memread  = 1'b1;
            w_ctrl.memtoreg = 1'b1;
            w_ctrl.regwrite = 1'b1;
            uses_rs1        = 1'b1;
         end
         c_OP_STORE: begin
            w_ctrl.aluop    = c_ALU_ADD;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.immsel   = c_IMM_S;
            w_ctrl.memwrite = 1'b1;
            uses_rs1        = 1'b1;
            uses_rs2        = 1'b1;
         end
         c_OP_BRANCH: begin
            w_ctrl.aluop    = c_ALU_CMP;
            w_ctrl.immsel   = c_IMM_B;
            w_ctrl.branch   = 1'b1;
            uses_rs1        = 1'b1;
            uses_rs2        = 1'b1;
         end
         c_OP_JAL: begin
            w_ctrl.aluop    = c_ALU_PCADD;
            w_ctrl.immsel   = c_IMM_J;
            w_ctrl.jump     = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.pc4sel   = 1'b1;
         end
         c_OP_JALR: begin
            w_ctrl.aluop    = c_ALU_ADD;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.immsel   = c_IMM_I;
            w_ctrl.jump     = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.pc4sel   = 1'b1;
            uses_rs1        = 1'b1;
         end
         c_OP_LUI: begin
            w_ctrl.aluop    = c_ALU_PASSIMM;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.immsel   = c_IMM_U;
            w_ctrl.regwrite = 1'b1;
         end
         c_OP_AUIPC: begin
            w_ctrl.aluop    = c_ALU_PCADD;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.immsel   = c_IMM_U;
            w_ctrl.regwrite = 1'b1;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
      // x0 is hardwired to zero, so a write to it is never architecturally visible
      if (rd == '0) begin
         w_ctrl.regwrite = 1'b0;
      end
   end

   assign bundle = w_ctrl;

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/ctrl_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_unit
// Brief    : ID-stage decode, load-use hazard stall and EX/MEM/WB control
//            pipeline with flush handling and illegal-opcode counter.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipe_unit
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int HAZARD_EN  = 1,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [6:0]            opcode,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  ex_flush,
   output logic                  stall,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [CTRL_W-1:0]     mem_ctrl,
   output logic [CTRL_W-1:0]     wb_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  ex_valid,
   output logic                  mem_valid,
   output logic                  wb_valid,
   output logic                  ex_illegal,
   output logic [CNT_W-1:0]      illegal_cnt
);

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CTRL_W-1:0]     w_bundle;
   logic                  w_illegal;
   logic                  w_uses_rs1;
   logic                  w_uses_rs2;
   logic                  w_hazard;
   logic                  w_ex_load;

   logic                  ex_valid_q,   ex_valid_d;
   logic [CTRL_W-1:0]     ex_ctrl_q,    ex_ctrl_d;
   logic [REG_ADDR_W-1:0] ex_rd_q,      ex_rd_d;
   logic                  ex_illegal_q, ex_illegal_d;
   logic                  mem_valid_q;
   logic [CTRL_W-1:0]     mem_ctrl_q;
   logic [REG_ADDR_W-1:0] mem_rd_q;
   logic                  wb_valid_q;
   logic [CTRL_W-1:0]     wb_ctrl_q;
   logic [REG_ADDR_W-1:0] wb_rd_q;
   logic [CNT_W-1:0]      illegal_cnt_q, illegal_cnt_d;

   ctrl_decode #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_decode (
      .opcode   (opcode),
      .rd       (rd),
      .bundle   (w_bundle),
      .illegal  (w_illegal),
      .uses_rs1 (w_uses_rs1),
      .uses_rs2 (w_uses_rs2)
   );

   generate
      if (HAZARD_EN != 0) begin : g_hazard
         assign w_hazard = id_valid && ex_valid_q && ex_ctrl_q[c_BIT_MEMREAD] &&
                           (ex_rd_q != '0) &&
                           ((w_uses_rs1 && (rs1 == ex_rd_q)) ||
                            (w_uses_rs2 && (rs2 == ex_rd_q)));
      end else begin : g_no_hazard
         assign w_hazard = 1'b0;
      end
   endgenerate

   // A flush discards the ID instruction anyway, so holding IF/ID would be pointless
   assign stall     = w_hazard && !ex_flush;
   assign w_ex_load = id_valid && !stall && !ex_flush;

   always_comb begin
      ex_valid_d    = w_ex_load;
      ex_ctrl_d     = w_ex_load ? w_bundle : '0;
      ex_rd_d       = w_ex_load ? rd : '0;
      ex_illegal_d  = w_ex_load && w_illegal;
      illegal_cnt_d = illegal_cnt_q;
      if (ex_illegal_d && (illegal_cnt_q != '1)) begin
         illegal_cnt_d = illegal_cnt_q + c_CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid_q    <= 1'b0;
         ex_ctrl_q     <= '0;
         ex_rd_q       <= '0;
         ex_illegal_q  <= 1'b0;
         mem_valid_q   <= 1'b0;
         mem_ctrl_q    <= '0;
         mem_rd_q      <= '0;
         wb_valid_q    <= 1'b0;
         wb_ctrl_q     <= '0;
         wb_rd_q       <= '0;
         illegal_cnt_q <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_rd_q       <= ex_rd_d;
         ex_illegal_q  <= ex_illegal_d;
         mem_valid_q   <= ex_valid_q;
         mem_ctrl_q    <= ex_ctrl_q;
         mem_rd_q      <= ex_rd_q;
         wb_valid_q    <= mem_valid_q;
         wb_ctrl_q     <= mem_ctrl_q;
         wb_rd_q       <= mem_rd_q;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign mem_valid   = mem_valid_q;
   assign wb_valid    = wb_valid_q;
   assign ex_ctrl     = ex_valid_q  ? ex_ctrl_q  : '0;
   assign mem_ctrl    = mem_valid_q ? mem_ctrl_q : '0;
   assign wb_ctrl     = wb_valid_q  ? wb_ctrl_q  : '0;
   assign ex_rd       = ex_rd_q;
   assign mem_rd      = mem_rd_q;
   assign wb_rd       = wb_rd_q;
   assign ex_illegal  = ex_illegal_q;
   assign illegal_cnt = illegal_cnt_q;

endmodule : ctrl_pipe_unit
`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_unit
// Brief    : Directed scoreboard bench for ctrl_pipe_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe_unit;

   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 8;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        id_valid = 1'b0;
   logic        ex_flush = 1'b0;
   logic [6:0]  opcode   = '0;
   logic [4:0]  rd       = '0;
   logic [4:0]  rs1      = '0;
   logic [4:0]  rs2      = '0;

   logic        stall;
   logic [13:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_valid, mem_valid, wb_valid, ex_illegal;
   logic [7:0]  illegal_cnt;

   int          checks   = 0;
   int          failures = 0;
   int          exp_cnt  = 0;
   logic [18:0] exp_q[$];

   ctrl_pipe_unit #(
      .REG_ADDR_W (REG_ADDR_W),
      .HAZARD_EN  (1),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .opcode      (opcode),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .ex_flush    (ex_flush),
      .stall       (stall),
      .ex_ctrl     (ex_ctrl),
      .mem_ctrl    (mem_ctrl),
      .wb_ctrl     (wb_ctrl),
      .ex_rd       (ex_rd),
      .mem_rd      (mem_rd),
      .wb_rd       (wb_rd),
      .ex_valid    (ex_valid),
      .mem_valid   (mem_valid),
      .wb_valid    (wb_valid),
      .ex_illegal  (ex_illegal),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_JAL = 7'b1101111;
   localparam logic [13:0] B_R = 14'h1002, B_I = 14'h1402, B_LD = 14'h0416;
   localparam logic [13:0] B_ST = 14'h0488, B_JAL = 14'h2223;

   logic [6:0]  ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
   logic [13:0] bnds[10] = '{14'h1002, 14'h1402, 14'h0416, 14'h0488, 14'h0940,
                             14'h2223, 14'h0423, 14'h1D82, 14'h2582, 14'h0000};
   logic [6:0]  ill [4]  = '{7'h00, 7'h7F, 7'h0F, 7'h73};

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [69:0] all_outs();
      return {stall, ex_valid, mem_valid, wb_valid, ex_illegal, ex_ctrl, mem_ctrl, wb_ctrl,
              ex_rd, mem_rd, wb_rd, illegal_cnt};
   endfunction

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic fl);
      id_valid = v; opcode = op; rd = d; rs1 = s1; rs2 = s2; ex_flush = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
      repeat (n) tick();
   endtask

   // Scoreboard monitor: every retiring WB instruction must match the queue head
   initial begin
      logic [18:0] e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            if (wb_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL wb_unexpected actual=ctrl %h rd %0d required=no retire", wb_ctrl, wb_rd);
               end else begin
                  e = exp_q.pop_front();
                  check("wb_bundle", {wb_ctrl, wb_rd}, e);
               end
            end else begin
               check("wb_idle", {wb_valid, wb_ctrl}, 0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
      repeat (2) tick();
      check("reset_state", all_outs(), 0);
      reset = 1'b1;

      // Every opcode class once, rd=3
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, ops[i], 5'd3, 5'd1, 5'd2, 1'b0);
         check("stall_none", stall, 0);
         exp_q.push_back({bnds[i], 5'd3});
         tick();
         check("ex_ctrl", {ex_valid, ex_ctrl}, {1'b1, bnds[i]});
         check("ex_illegal", ex_illegal, (i == 9));
      end
      drive(1'b1, OP_R, 5'd0, 5'd1, 5'd2, 1'b0);
      exp_q.push_back({14'h1000, 5'd0});
      tick();
      check("rd0_regwrite", ex_ctrl, 14'h1000);
      idle(4);
      exp_cnt = 1;
      check("cnt_one", illegal_cnt, exp_cnt);

      // lw x5 ; add x6,x5,x7
      drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
      exp_q.push_back({B_LD, 5'd5});
      tick();
      drive(1'b1, OP_R, 5'd6, 5'd5, 5'd7, 1'b0);
      check("stall_loaduse", stall, 1);
      tick();
      check("ex_bubble", {ex_valid, ex_ctrl}, 0);
      check("stall_release", stall, 0);
      exp_q.push_back({B_R, 5'd6});
      tick();
      check("ex_after_stall", {ex_valid, ex_rd}, {1'b1, 5'd6});

      // Load-use through rs2 of a store
      drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
      exp_q.push_back({B_LD, 5'd5});
      tick();
      drive(1'b1, OP_ST, 5'd0, 5'd1, 5'd5, 1'b0);
      check("stall_rs2", stall, 1);
      tick();
      exp_q.push_back({B_ST, 5'd0});
      tick();

      // jal does not read rs1 even if the field matches
      drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
      exp_q.push_back({B_LD, 5'd5});
      tick();
      drive(1'b1, OP_JAL, 5'd1, 5'd5, 5'd5, 1'b0);
      check("stall_jal", stall, 0);
      exp_q.push_back({B_JAL, 5'd1});
      tick();

      // lw x5 ; add x6,x0,x0  and  lw x0 ; add x6,x0,x0
      drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
      exp_q.push_back({B_LD, 5'd5});
      tick();
      drive(1'b1, OP_R, 5'd6, 5'd0, 5'd0, 1'b0);
      check("stall_x0_src", stall, 0);
      exp_q.push_back({B_R, 5'd6});
      tick();
      drive(1'b1, OP_LD, 5'd0, 5'd0, 5'd0, 1'b0);
      exp_q.push_back({14'h0414, 5'd0});
      tick();
      drive(1'b1, OP_R, 5'd6, 5'd0, 5'd0, 1'b0);
      check("stall_x0_dst", stall, 0);
      exp_q.push_back({B_R, 5'd6});
      tick();

      // Flush with a pending load-use hazard
      drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
      exp_q.push_back({B_LD, 5'd5});
      tick();
      drive(1'b1, OP_R, 5'd6, 5'd5, 5'd7, 1'b1);
      check("stall_flush", stall, 0);
      tick();
      check("ex_flushed", {ex_valid, ex_ctrl}, 0);
      check("mem_after_flush", {mem_valid, mem_rd, mem_ctrl}, {1'b1, 5'd5, B_LD});
      idle(4);

      // Illegal counter saturation
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, ill[i % 4], 5'(i), 5'd1, 5'd2, 1'b0);
         exp_q.push_back({14'h0000, 5'(i)});
         tick();
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         check("cnt_step", illegal_cnt, exp_cnt);
      end
      check("cnt_sat", illegal_cnt, 8'hFF);
      idle(4);

      // Reset in the middle of traffic
      drive(1'b1, OP_R, 5'd8, 5'd1, 5'd2, 1'b0);
      exp_q.push_back({B_R, 5'd8});
      tick();
      drive(1'b1, OP_I, 5'd9, 5'd1, 5'd2, 1'b0);
      exp_q.push_back({B_I, 5'd9});
      tick();
      drive(1'b1, OP_LD, 5'd10, 5'd1, 5'd2, 1'b0);
      tick();
      drive(1'b1, OP_R, 5'd11, 5'd10, 5'd2, 1'b0);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("reset_async", all_outs(), 0);
      tick();
      check("reset_hold", all_outs(), 0);
      reset = 1'b1;
      drive(1'b1, OP_R, 5'd11, 5'd1, 5'd2, 1'b0);
      exp_q.push_back({B_R, 5'd11});
      tick();
      check("ex_first_after_reset", {ex_valid, ex_rd, ex_ctrl}, {1'b1, 5'd11, B_R});
      check("cnt_after_reset", illegal_cnt, 0);
      idle(5);
      check("sb_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ctrl_pipe_unit
`default_nettype wire

// File: doc/ctrl_pipe_unit.md
CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-specifier width (4 for RV32E).
REQ-002 SHALL have parameter HAZARD_EN, default 1, enables load-use stall logic (0: stall tied low).
REQ-003 SHALL have parameter CNT_W, default 8, illegal-opcode counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port id_valid  input  1  ID stage holds a valid instruction.
REQ-007 SHALL have port opcode  input  7  instruction[6:0] in ID.
REQ-008 SHALL have ports rd, rs1, rs2  input  REG_ADDR_W each  ID register specifiers.
REQ-009 SHALL have port ex_flush  input  1  taken branch/jump resolved in EX.
REQ-010 SHALL have port stall  output  1  hold PC and IF/ID register (combinational).
REQ-011 SHALL have ports ex_ctrl, mem_ctrl, wb_ctrl  output  CTRL_W each  per-stage control bundle.
REQ-012 SHALL have ports ex_rd, mem_rd, wb_rd  output  REG_ADDR_W each  per-stage destination.
REQ-013 SHALL have ports ex_valid, mem_valid, wb_valid  output  1 each  stage occupancy.
REQ-014 SHALL have port ex_illegal  output  1  EX instruction had unsupported opcode.
REQ-015 SHALL have port illegal_cnt  output  CNT_W  saturating count of illegal opcodes retired to EX.

Function
REQ-016 SHALL decode a ctrl bundle {aluop[2:0], alusrc, immsel[2:0], branch, jump, memread, memwrite, memtoreg, regwrite, pc4sel}, CTRL_W=14; aluop 000 add, 001 compare, 010 funct, 011 pass-imm, 100 pc-add; immsel 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-017 SHALL decode: R 0110011 -> aluop010 regwrite; I 0010011 -> aluop010 alusrc immI regwrite; load 0000011 -> aluop000 alusrc immI memread memtoreg regwrite.
REQ-018 SHALL decode: store 0100011 -> aluop000 alusrc immS memwrite; branch 1100011 -> aluop001 immB branch.
REQ-019 SHALL decode: jal 1101111 -> aluop100 immJ jump regwrite pc4sel; jalr 1100111 -> aluop000 alusrc immI jump regwrite pc4sel.
REQ-020 SHALL decode: lui 0110111 -> aluop011 alusrc immU regwrite; auipc 0010111 -> aluop100 alusrc immU regwrite.
REQ-021 SHALL decode any other opcode to all-zero bundle with illegal=1; unlisted fields are 0, never X.
REQ-022 SHALL force regwrite=0 in the bundle when rd==0.
REQ-023 SHALL assert stall when HAZARD_EN, id_valid, ex_valid, ex_ctrl.memread, ex_rd!=0 and ex_rd matches rs1 (opcode uses rs1) or rs2 (opcode uses rs2); rs1 used by R/I/load/store/branch/jalr, rs2 by R/store/branch.
REQ-024 SHALL advance EX->MEM->WB every cycle unconditionally (latency ID to WB = 3 cycles).
REQ-025 SHALL load EX with a bubble (valid=0, ctrl=0, illegal=0) when stall, ex_flush, or !id_valid; else with decoded ID data.
REQ-026 SHALL, on ex_flush with stall, give flush priority and drive stall=0.
REQ-027 SHALL not flush the EX instruction itself; it proceeds to MEM.
REQ-028 SHALL increment illegal_cnt when an illegal instruction enters EX, saturating at all-ones.
REQ-029 SHALL zero ctrl outputs of any stage whose valid is 0.

Reset
REQ-030 SHALL, while reset=0, clear all valids, ctrl bundles, rd fields, ex_illegal and illegal_cnt to 0 asynchronously; stall reads 0.
REQ-031 SHALL, on reset mid-operation, discard all in-flight instructions; first valid EX one cycle after reset release with id_valid=1.

Structure
REQ-032 SHALL place CTRL_W, opcode constants, aluop and immsel encodings and bundle field offsets in shared package ctrl_pkg.
REQ-033 SHALL contain one combinational sub-module ctrl_decode (opcode, rd -> bundle, illegal, uses_rs1, uses_rs2).

Verification
REQ-034 SHALL cover: lw x5 then add x6,x5,x7 back-to-back -> stall=1 one cycle, EX bubble, add enters EX next cycle.
REQ-035 SHALL cover: lw x5 then add x6,x0,x0 -> no stall; lw x0 then add x6,x0,x0 -> no stall.
REQ-036 SHALL cover: ex_flush=1 with stall condition -> stall=0, ex_valid=0 next cycle, prior EX reaches MEM.
REQ-037 SHALL cover: each of the 9 opcodes plus 0000000 -> exact bundle per REQ-017..021, visible on wb_ctrl 3 cycles later.
REQ-038 SHALL cover: 300 illegal opcodes with CNT_W=8 -> illegal_cnt saturates at 255.
REQ-039 SHALL cover: reset asserted mid-stream -> all outputs 0 same cycle, no X.
